// File: rtl/idelay_lane_scheduler.sv
// Round-robin, step-limited IDELAY tap updater: one shared write path services up to
// eight lanes, moving at most STEP_MAX taps per write with a settle gap after each write.
module idelay_lane_scheduler #(
    parameter int unsigned NLANES   = 4,
    parameter int unsigned STEP_MAX = 8,
    parameter int unsigned SETTLE   = 4
) (
    input  logic                clk160_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic [9*NLANES-1:0] delay_target_i,
    input  logic [9*NLANES-1:0] delay_out_i,
    output logic [8:0]          delay_set_value_o,
    output logic [NLANES-1:0]   delay_wr_o,
    output logic [2:0]          active_lane_o,
    output logic [NLANES-1:0]   lane_ready_o,
    output logic                all_ready_o,
    output logic                busy_o
);

    typedef enum logic [1:0] {StArb, StCalc, StWrite, StSettle} state_e;

    localparam logic signed [9:0] StepMax    = 10'(STEP_MAX);
    localparam logic [3:0]        SettleInit = 4'(SETTLE - 1);
    localparam logic [3:0]        NLanes4    = 4'(NLANES);

    state_e            state_q, state_d;
    logic [2:0]        rr_ptr_q, rr_ptr_d;
    logic [2:0]        active_lane_q, active_lane_d;
    logic [8:0]        tgt_h_q, tgt_h_d;
    logic [8:0]        out_h_q, out_h_d;
    logic [8:0]        set_value_q, set_value_d;
    logic [NLANES-1:0] wr_q, wr_d;
    logic [3:0]        cnt_q, cnt_d;

    for (genvar i = 0; i < NLANES; i++) begin : g_ready
        assign lane_ready_o[i] = (delay_target_i[9*i +: 9] == delay_out_i[9*i +: 9]);
    end
    assign all_ready_o = &lane_ready_o;

    // Round-robin search: iterate from the farthest offset down so the nearest mismatch wins.
    logic [7:0] ready8;
    logic [3:0] sum4;
    logic [2:0] idx3;
    logic       found;
    logic [2:0] sel;
    logic [8:0] sel_tgt, sel_out;

    always_comb begin
        ready8                = '1;
        ready8[NLANES-1:0]    = lane_ready_o;
        found                 = 1'b0;
        sel                   = '0;
        sum4                  = '0;
        idx3                  = '0;
        for (int k = NLANES - 1; k >= 0; k--) begin
            sum4 = {1'b0, rr_ptr_q} + 4'(k);
            idx3 = (sum4 >= NLanes4) ? 3'(sum4 - NLanes4) : sum4[2:0];
            if (!ready8[idx3]) begin
                found = 1'b1;
                sel   = idx3;
            end
        end
        sel_tgt = '0;
        sel_out = '0;
        for (int i = 0; i < NLANES; i++) begin
            if (3'(i) == sel) begin
                sel_tgt = delay_target_i[9*i +: 9];
                sel_out = delay_out_i[9*i +: 9];
            end
        end
    end

    logic signed [9:0] diff, step;

    always_comb begin
        diff = $signed({1'b0, tgt_h_q}) - $signed({1'b0, out_h_q});
        if (diff > StepMax) begin
            step = StepMax;
        end else if (diff < -StepMax) begin
            step = -StepMax;
        end else begin
            step = diff;
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        active_lane_d = active_lane_q;
        tgt_h_d       = tgt_h_q;
        out_h_d       = out_h_q;
        set_value_d   = set_value_q;
        wr_d          = '0;
        cnt_d         = cnt_q;
        unique case (state_q)
            StArb: begin
                if (enable_i && found) begin
                    active_lane_d = sel;
                    tgt_h_d       = sel_tgt;
                    out_h_d       = sel_out;
                    state_d       = StCalc;
                end
            end
            StCalc: begin
                set_value_d = out_h_q + 9'($unsigned(step));
                for (int i = 0; i < NLANES; i++) begin
                    wr_d[i] = (3'(i) == active_lane_q);
                end
                state_d = StWrite;
            end
            StWrite: begin
                cnt_d   = SettleInit;
                state_d = StSettle;
            end
            StSettle: begin
                rr_ptr_d = (active_lane_q == 3'(NLANES - 1)) ? 3'd0 : active_lane_q + 3'd1;
                if (cnt_q == 4'd0) begin
                    state_d = StArb;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StArb;
        endcase
    end

    always_ff @(posedge clk160_i) begin
        if (rst_i) begin
            state_q       <= StArb;
            rr_ptr_q      <= '0;
            active_lane_q <= '0;
            tgt_h_q       <= '0;
            out_h_q       <= '0;
            set_value_q   <= '0;
            wr_q          <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            active_lane_q <= active_lane_d;
            tgt_h_q       <= tgt_h_d;
            out_h_q       <= out_h_d;
            set_value_q   <= set_value_d;
            wr_q          <= wr_d;
            cnt_q         <= cnt_d;
        end
    end

    assign delay_set_value_o = set_value_q;
    assign delay_wr_o        = wr_q;
    assign active_lane_o     = active_lane_q;
    assign busy_o            = (state_q != StArb);

endmodule
